// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first so HEX_SEG[code] indexes naturally.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-code to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[code];

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed seven-segment driver with per-frame input capture and anode guard.
// Optional build macro SEG7_DIM_EN adds the 2-bit bright input for reduced lit windows.
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] blank,
`ifdef SEG7_DIM_EN
  input  logic [1:0] bright,
`endif
  output logic [6:0] out,
  output logic       an0,
  output logic       an1,
  output logic       an2,
  output logic       an3
);

  localparam int                CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W:0]    GUARD_C  = (CNT_W+1)'(GUARD);
`ifdef SEG7_DIM_EN
  localparam int                WIN      = (REFRESH_DIV - GUARD) >> 2;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [3:0][3:0]  sd_q, sd_d;
  logic [3:0]       sb_q, sb_d;
  logic [6:0]       out_q, out_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       dec_seg;
  logic [CNT_W:0]   lit_end;
  logic             capture;
  logic             lit;
`ifdef SEG7_DIM_EN
  logic [1:0]       sbr_q, sbr_d;
`endif

  seg7_hex_decode u_dec (
    .code (sd_q[idx_q]),
    .seg  (dec_seg)
  );

  // End (exclusive) of the lit window within a slot, measured in slot counts.
  always_comb begin
    lit_end = (CNT_W+1)'(REFRESH_DIV);
`ifdef SEG7_DIM_EN
    case (sbr_q)
      2'd0:    lit_end = (CNT_W+1)'(GUARD + WIN);
      2'd1:    lit_end = (CNT_W+1)'(GUARD + 2 * WIN);
      2'd2:    lit_end = (CNT_W+1)'(GUARD + 3 * WIN);
      default: lit_end = (CNT_W+1)'(REFRESH_DIV);
    endcase
`endif
  end

  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d   = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
    capture = (idx_q == 2'd0) && (cnt_q == '0);
    sd_d    = capture ? {d3, d2, d1, d0} : sd_q;
    sb_d    = capture ? blank : sb_q;
`ifdef SEG7_DIM_EN
    sbr_d   = capture ? bright : sbr_q;
`endif
    lit     = ({1'b0, cnt_q} >= GUARD_C) && ({1'b0, cnt_q} < lit_end);
    an_d    = 4'hF;
    out_d   = SEG_OFF;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      out_d       = sb_q[idx_q] ? SEG_OFF : dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      sd_q  <= '0;
      sb_q  <= 4'hF;
      out_q <= SEG_OFF;
      an_q  <= 4'hF;
`ifdef SEG7_DIM_EN
      sbr_q <= 2'd0;
`endif
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sd_q  <= sd_d;
      sb_q  <= sb_d;
      out_q <= out_d;
      an_q  <= an_d;
`ifdef SEG7_DIM_EN
      sbr_q <= sbr_d;
`endif
    end
  end

  assign out = out_q;
  assign an0 = an_q[0];
  assign an1 = an_q[1];
  assign an2 = an_q[2];
  assign an3 = an_q[3];

endmodule

// File: tb/tb_seg7_scan4.sv
// Randomized bench for seg7_scan4 against a frame/slot arithmetic model (REFRESH_DIV=8, GUARD=2).
module tb_seg7_scan4;

  localparam int RD = 8;
  localparam int G  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d0, d1, d2, d3, blank;
`ifdef SEG7_DIM_EN
  logic [1:0] bright;
  logic [1:0] mbr;
`endif
  logic [6:0] out;
  logic       an0, an1, an2, an3;
  logic [3:0] an;

  assign an = {an3, an2, an1, an0};

  seg7_scan4 #(.REFRESH_DIV(RD), .GUARD(G)) dut (
    .clk   (clk),
    .rst   (rst),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .blank (blank),
`ifdef SEG7_DIM_EN
    .bright(bright),
`endif
    .out   (out),
    .an0   (an0),
    .an1   (an1),
    .an2   (an2),
    .an3   (an3)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int total = 0;
  int bad   = 0;
  int e     = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t counts clocks since reset release; slot = (t/RD)%4, position = t%RD.
  int         mt;
  logic [15:0] msd;
  logic [3:0]  msb;
  logic [6:0]  exp_out;
  logic [3:0]  exp_an;

  function automatic logic [10:0] model_cycle(input int tt, input logic [15:0] sdv,
                                              input logic [3:0] sbv);
    int slot, pos, len;
    logic [3:0] a;
    logic [6:0] o;
    slot = (tt / RD) % 4;
    pos  = tt % RD;
`ifdef SEG7_DIM_EN
    len = (mbr == 2'd3) ? (RD - G) : ((RD - G) / 4) * (int'(mbr) + 1);
`else
    len = RD - G;
`endif
    a = 4'hF;
    o = 7'h7F;
    if (pos >= G && pos < G + len) begin
      a[slot] = 1'b0;
      if (!sbv[slot]) o = seg_tab[sdv[slot*4 +: 4]];
    end
    return {a, o};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mt      <= 0;
      msd     <= '0;
      msb     <= 4'hF;
      exp_an  <= 4'hF;
      exp_out <= 7'h7F;
`ifdef SEG7_DIM_EN
      mbr     <= 2'd0;
`endif
    end else begin
      {exp_an, exp_out} <= model_cycle(mt, msd, msb);
      if (mt % (4 * RD) == 0) begin
        msd <= {d3, d2, d1, d0};
        msb <= blank;
`ifdef SEG7_DIM_EN
        mbr <= bright;
`endif
      end
      mt <= mt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out", {25'd0, out}, {25'd0, exp_out});
      check("an", {28'd0, an}, {28'd0, exp_an});
      check("one_anode", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    end
  end

  task automatic to_edge(input int k);
    repeat (k - e) @(posedge clk);
    e = k;
    #1;
  endtask

  task automatic lit_check(input string nm, input int k, input logic [3:0] a, input logic [6:0] o);
    to_edge(k);
    check({nm, "_an"}, {28'd0, an}, {28'd0, a});
    check({nm, "_out"}, {25'd0, out}, {25'd0, o});
  endtask

  task automatic rand_inputs();
    d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
    blank = 4'($urandom);
`ifdef SEG7_DIM_EN
    bright = 2'($urandom);
`endif
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) rand_inputs();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int lit_cnt;
    rst = 1'b0;
    rand_inputs();
    @(posedge clk);
    #1;
    check("rst_out", {25'd0, out}, 32'h7F);
    check("rst_an", {28'd0, an}, 32'hF);
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rand_inputs();
    end
    @(negedge clk);
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4; blank = 4'b0000;
`ifdef SEG7_DIM_EN
    bright = 2'd3;
`endif
    @(negedge clk);
    rst = 1'b1;
    e = 0;
    lit_check("guard_after_rel", 2, 4'hF, 7'h7F);
    lit_check("first_lit", 3, 4'b1110, 7'h79);
    lit_check("slot1_guard", 10, 4'hF, 7'h7F);
    lit_check("slot1_lit", 11, 4'b1101, 7'h24);
    @(negedge clk);
    d2 = 4'hE;
    lit_check("d2_old", 19, 4'b1011, 7'h30);
    lit_check("d3_lit", 27, 4'b0111, 7'h19);
    lit_check("d2_new", 51, 4'b1011, 7'h06);
    @(negedge clk);
    blank = 4'b0101;
    lit_check("blank0", 67, 4'b1110, 7'h7F);
    lit_check("blank1", 75, 4'b1101, 7'h24);
    lit_check("blank2", 83, 4'b1011, 7'h7F);
    lit_check("blank3", 91, 4'b0111, 7'h19);

    rand_phase(1500);

    found = 0;
    for (int i = 0; i < 64 && found == 0; i++) begin
      @(negedge clk);
      if (an == 4'b1011) found = 1;
    end
    check("an2_seen", found, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out", {25'd0, out}, 32'h7F);
    check("async_rst_an", {28'd0, an}, 32'hF);
    repeat (3) @(negedge clk);
    d0 = 4'd8; blank = 4'b0000;
`ifdef SEG7_DIM_EN
    bright = 2'd3;
`endif
    @(negedge clk);
    rst = 1'b1;
    e = 0;
    lit_check("restart_an0", 3, 4'b1110, 7'h00);

`ifdef SEG7_DIM_EN
    @(negedge clk);
    bright = 2'd0;
    lit_cnt = 0;
    for (int k = 9; k <= 16; k++) begin
      to_edge(k);
      if (an[1] == 1'b0) lit_cnt++;
    end
    check("dim_midframe_width", lit_cnt, 6);
    lit_cnt = 0;
    for (int k = 33; k <= 40; k++) begin
      to_edge(k);
      if (an[0] == 1'b0) lit_cnt++;
    end
    check("dim0_width", lit_cnt, 1);
`else
    lit_cnt = 0;
    for (int k = 9; k <= 16; k++) begin
      to_edge(k);
      if (an[1] == 1'b0) lit_cnt++;
    end
    check("full_width", lit_cnt, 6);
`endif

    rand_phase(1500);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan4.md
# seg7_scan4

Four-digit multiplexed seven-segment display driver, downstream of the sequence-detector and counter stages. It takes four 4-bit hex digit codes plus per-digit blanking, captures them once per frame so the display never tears, and time-multiplexes them onto one shared active-low segment bus and four active-low anodes. A guard interval at each digit change prevents ghosting.

## Interface
- REFRESH_DIV, 50000: clocks per digit slot; frame = 4*REFRESH_DIV clocks; legal range 8..2^20.
- GUARD, 4: clocks at slot start with all anodes off; legal range 1..REFRESH_DIV/2.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- d0, d1, d2, d3  in  4 each  hex codes; d0 drives rightmost digit (an0), d3 leftmost (an3).
- blank  in  4  blank[i]=1 forces digit i dark regardless of di.
- out  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an0, an1, an2, an3  out  1 each  digit anodes, active-low; at most one low at any time.

## Operation
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..3), shadow digits sd0..sd3, shadow blank sb.
- cnt increments each clock; at REFRESH_DIV-1 it wraps to 0 and idx advances 0->1->2->3->0.
- Frame capture: on every clock where idx==0 and cnt==0, shadows load from d0..d3 and blank. Inputs are ignored at all other times; mid-frame input changes show only from the next frame.
- Decode, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex); blank=7F.
- Registered outputs, computed each clock from current (idx, cnt, shadows):
  - cnt < GUARD: all anodes high, out=7F.
  - otherwise: anode idx low, out = decode(sd[idx]), or 7F with anode still low if sb[idx]=1.
- Reset asserted: cnt=0, idx=0, shadows = 0 with sb=4'b1111, out=7F, an0..an3=1. Reset mid-slot aborts the slot immediately; first capture occurs on the first clock after release.

## Timing
- Outputs lag internal state by exactly one clock; out and anodes always change on the same edge.
- An input change is visible at the earliest GUARD+1 clocks after the capture cycle for digit 0 and at most one frame plus GUARD+1 clocks after it.
- Per slot: GUARD clocks dark, then REFRESH_DIV-GUARD clocks lit (full brightness).
- Anode hand-off: the previous anode goes high on the same edge that the guard begins; two anodes are never low together, including across reset.
- Input codes are 4-bit, so no out-of-range handling is needed; all 16 codes decode.

## Configuration
- SEG7_DIM_EN defined: adds port bright in 2 (brightness 0..3), captured with the shadows at frame start. The lit window is reduced to W*(bright+1) clocks, where W=(REFRESH_DIV-GUARD)>>2. With bright=3 the window is the full REFRESH_DIV-GUARD. The rest of the slot is dark (anodes high, out=7F).
- SEG7_DIM_EN undefined: no bright port; always full brightness.

## Structure
- Package seg7_pkg: SEG_OFF (7'h7F), 16-entry hex segment constant array, digit index type (2 bits).
- Sub-module seg7_hex_decode: combinational 4-bit code to 7-bit active-low pattern. seg7_scan4 instantiates it once on the muxed shadow digit.
- The top level holds the counters, shadows, and output registers.

## Test plan
All scenarios use REFRESH_DIV=8 and GUARD=2 (32-clock frame).
- Reset held, inputs toggling -> out=7F and all anodes high every cycle. Release -> first lit anode an0 appears exactly 3 clocks after release.
- d0..d3 = 1,2,3,4, blank=0 -> an0..an3 low in turn, each for 6 clocks with 2 dark clocks between. out=79, 24, 30, 19 respectively.
- Change d2 from 3 to E mid-frame -> digit 2 keeps 30 for the rest of this frame and shows 06 from the next frame.
- blank=4'b0101 -> an0 and an2 still pulse with out=7F; an1 and an3 show their decoded values.
- Assert reset while an2 is lit -> all anodes high and out=7F with no clock edge needed. After release, scanning restarts from an0.
- SEG7_DIM_EN with bright = 0, 1, 2, 3 -> lit windows of 1, 2, 3, 6 clocks per slot. A bright change mid-frame takes effect only at the next frame.
